// File: rtl/dmem_arbiter_2core.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_2core
//
// Shares one data-memory port between the MEM stages of two cores. Requests
// are granted round-robin. The granted access is latched and presented to
// memory until mem_ready. Read data is returned through a registered
// per-core rdata with a one-cycle done pulse. A requesting core is stalled
// until its own done pulse.
//
// Optional feature: define DMEM_ARB_LOCK_EN to add cN_lock inputs and a
// LOCKED state. In LOCKED, the previous owner keeps the port across several
// accesses, for example an AMO read-modify-write pair.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   cN_req/we/addr/wdata   core N access request (level, held until cN_done)
//   cN_lock                core N atomic lock (DMEM_ARB_LOCK_EN only)
//   cN_stall               freeze core N EX/MEM register
//   cN_done, cN_rdata      completion pulse and load data for core N
//   mem_req/we/addr/wdata  shared memory access, stable until mem_ready
//   mem_ready, mem_rdata   memory completion and read data
//   owner, busy            current grant holder, access/lock in progress
// ---------------------------------------------------------------------------
module dmem_arbiter_2core #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              c0_lock,
`endif
  output logic              c0_stall,
  output logic              c0_done,
  output logic [DATA_W-1:0] c0_rdata,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic              c1_lock,
`endif
  output logic              c1_stall,
  output logic              c1_done,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
);

`ifdef DMEM_ARB_LOCK_EN
  typedef enum logic [1:0] {IDLE, BUSY, LOCKED} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif

  state_t              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;

  logic                elig0, elig1;
  logic                grant, gsel;

  // A core's request is ignored in its done cycle. The core is then
  // presenting its next request, which must not be served twice.
  assign elig0 = c0_req & ~done0_q;
  assign elig1 = c1_req & ~done1_q;

`ifdef DMEM_ARB_LOCK_EN
  logic own_elig, own_lock;
  assign own_elig = owner_q ? elig1 : elig0;
  assign own_lock = owner_q ? c1_lock : c0_lock;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    grant    = 1'b0;
    gsel     = 1'b0;

    case (state_q)
      IDLE: begin
        if (elig0 && elig1) begin
          grant = 1'b1;
          gsel  = ~last_q;
        end else if (elig0) begin
          grant = 1'b1;
          gsel  = 1'b0;
        end else if (elig1) begin
          grant = 1'b1;
          gsel  = 1'b1;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          // Read data is returned on stores as well; the core ignores it.
          if (owner_q) begin
            rdata1_d = mem_rdata;
            done1_d  = 1'b1;
          end else begin
            rdata0_d = mem_rdata;
            done0_d  = 1'b1;
          end
          last_d = owner_q;
`ifdef DMEM_ARB_LOCK_EN
          state_d = own_lock ? LOCKED : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef DMEM_ARB_LOCK_EN
      LOCKED: begin
        // Only the lock holder may start an access. There is no arbitration.
        if (own_elig) begin
          grant = 1'b1;
          gsel  = owner_q;
        end else if (!own_lock) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (grant) begin
      state_d = BUSY;
      owner_d = gsel;
      we_d    = gsel ? c1_we    : c0_we;
      addr_d  = gsel ? c1_addr  : c0_addr;
      wdata_d = gsel ? c1_wdata : c0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign mem_req   = (state_q == BUSY);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign c0_done   = done0_q;
  assign c1_done   = done1_q;
  assign c0_rdata  = rdata0_q;
  assign c1_rdata  = rdata1_q;
  assign c0_stall  = c0_req & ~done0_q;
  assign c1_stall  = c1_req & ~done1_q;

  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter_2core.sv
module tb_dmem_arbiter_2core;
  logic        clk;
  logic        rst;
  logic        c0_req, c0_we, c1_req, c1_we;
  logic [31:0] c0_addr, c0_wdata, c1_addr, c1_wdata;
  logic        c0_stall, c0_done, c1_stall, c1_done;
  logic [31:0] c0_rdata, c1_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        owner, busy;
`ifdef DMEM_ARB_LOCK_EN
  logic        c0_lock, c1_lock;
`endif

  int vec;
  int err;

  dmem_arbiter_2core #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .c0_lock(c0_lock),
`endif
    .c0_stall(c0_stall), .c0_done(c0_done), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
`ifdef DMEM_ARB_LOCK_EN
    .c1_lock(c1_lock),
`endif
    .c1_stall(c1_stall), .c1_done(c1_done), .c1_rdata(c1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_inputs();
    c0_req = 0; c0_we = 0; c0_addr = 0; c0_wdata = 0;
    c1_req = 0; c1_we = 0; c1_addr = 0; c1_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
`ifdef DMEM_ARB_LOCK_EN
    c0_lock = 0; c1_lock = 0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; clear_inputs();
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1; clear_inputs();
    @(negedge clk); #1;
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL rst_busy: got %b want 0", busy); end
    vec++; if (owner !== 1'b0) begin err++; $display("FAIL rst_owner: got %b want 0", owner); end
    vec++; if (mem_req !== 1'b0) begin err++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    vec++; if (mem_we !== 1'b0) begin err++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
    vec++; if (mem_addr !== 32'h0) begin err++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    vec++; if (mem_wdata !== 32'h0) begin err++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
    vec++; if ({c0_done, c1_done} !== 2'b00) begin err++; $display("FAIL rst_done: got %b want 00", {c0_done, c1_done}); end
    vec++; if (c0_rdata !== 32'h0) begin err++; $display("FAIL rst_c0_rdata: got %h want 0", c0_rdata); end
    vec++; if (c1_rdata !== 32'h0) begin err++; $display("FAIL rst_c1_rdata: got %h want 0", c1_rdata); end
    rst = 0;
  endtask

  task automatic test_single_load();
    // cycle 0
    @(negedge clk);
    c0_req = 1; c0_we = 0; c0_addr = 32'h100; mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    #1;
    vec++; if (c0_stall !== 1'b1) begin err++; $display("FAIL ld_c0_stall_c0: got %b want 1", c0_stall); end
    vec++; if (mem_req !== 1'b0) begin err++; $display("FAIL ld_mem_req_c0: got %b want 0", mem_req); end
    // cycle 1
    @(negedge clk); #1;
    vec++; if (mem_req !== 1'b1) begin err++; $display("FAIL ld_mem_req_c1: got %b want 1", mem_req); end
    vec++; if (mem_addr !== 32'h100) begin err++; $display("FAIL ld_mem_addr: got %h want 100", mem_addr); end
    vec++; if (mem_we !== 1'b0) begin err++; $display("FAIL ld_mem_we: got %b want 0", mem_we); end
    vec++; if (c0_stall !== 1'b1) begin err++; $display("FAIL ld_c0_stall_c1: got %b want 1", c0_stall); end
    vec++; if (busy !== 1'b1 || owner !== 1'b0) begin err++; $display("FAIL ld_busy_owner: got %b%b want 10", busy, owner); end
    // cycle 2
    @(negedge clk); #1;
    vec++; if (c0_done !== 1'b1) begin err++; $display("FAIL ld_c0_done: got %b want 1", c0_done); end
    vec++; if (c0_rdata !== 32'hDEADBEEF) begin err++; $display("FAIL ld_c0_rdata: got %h want deadbeef", c0_rdata); end
    vec++; if (c0_stall !== 1'b0) begin err++; $display("FAIL ld_c0_stall_c2: got %b want 0", c0_stall); end
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL ld_busy_c2: got %b want 0", busy); end
    c0_req = 0; mem_ready = 0; mem_rdata = 32'h12345678;
    // cycle 3
    @(negedge clk); #1;
    vec++; if (c0_done !== 1'b0) begin err++; $display("FAIL ld_c0_done_c3: got %b want 0", c0_done); end
    vec++; if (c0_rdata !== 32'hDEADBEEF) begin err++; $display("FAIL ld_c0_rdata_hold: got %h want deadbeef", c0_rdata); end
  endtask

  task automatic test_both_request();
    do_reset();
    // cycle 0
    @(negedge clk);
    c0_req = 1; c0_addr = 32'h10; c1_req = 1; c1_addr = 32'h14;
    mem_ready = 1; mem_rdata = 32'h1111;
    #1;
    vec++; if ({c0_stall, c1_stall} !== 2'b11) begin err++; $display("FAIL both_stall_c0: got %b want 11", {c0_stall, c1_stall}); end
    // cycle 1
    @(negedge clk); #1;
    vec++; if (mem_req !== 1'b1 || owner !== 1'b0) begin err++; $display("FAIL both_grant0: got req=%b owner=%b want 1 0", mem_req, owner); end
    vec++; if (mem_addr !== 32'h10) begin err++; $display("FAIL both_addr0: got %h want 10", mem_addr); end
    // cycle 2
    @(negedge clk); #1;
    vec++; if (c0_done !== 1'b1 || c0_rdata !== 32'h1111) begin err++; $display("FAIL both_c0_done: got %b %h want 1 1111", c0_done, c0_rdata); end
    vec++; if (c1_stall !== 1'b1) begin err++; $display("FAIL both_c1_stall_c2: got %b want 1", c1_stall); end
    c0_req = 0; mem_rdata = 32'h2222;
    // cycle 3
    @(negedge clk); #1;
    vec++; if (mem_req !== 1'b1 || owner !== 1'b1) begin err++; $display("FAIL both_grant1: got req=%b owner=%b want 1 1", mem_req, owner); end
    vec++; if (mem_addr !== 32'h14) begin err++; $display("FAIL both_addr1: got %h want 14", mem_addr); end
    vec++; if (c1_stall !== 1'b1 || c0_done !== 1'b0) begin err++; $display("FAIL both_c3: got stall1=%b done0=%b want 1 0", c1_stall, c0_done); end
    // cycle 4
    @(negedge clk); #1;
    vec++; if (c1_done !== 1'b1 || c1_rdata !== 32'h2222) begin err++; $display("FAIL both_c1_done: got %b %h want 1 2222", c1_done, c1_rdata); end
    vec++; if (c1_stall !== 1'b0 || c0_done !== 1'b0) begin err++; $display("FAIL both_c4: got stall1=%b done0=%b want 0 0", c1_stall, c0_done); end
    vec++; if (c0_rdata !== 32'h1111) begin err++; $display("FAIL both_c0_hold: got %h want 1111", c0_rdata); end
    c1_req = 0; mem_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic        o;
    logic [31:0] exp;
    // cycle 0 (last grant went to core 1, so core 0 wins the first tie)
    @(negedge clk);
    c0_req = 1; c0_addr = 32'h40; c1_req = 1; c1_addr = 32'h80;
    mem_ready = 1; mem_rdata = 32'hA000;
    #1;
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL b2b_idle: got %b want 0", busy); end
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      mem_rdata = 32'hA000 + c;
      #1;
      if (c % 2 == 1) begin
        o = ((c - 1) / 2) % 2 == 1;
        vec++; if (mem_req !== 1'b1 || owner !== o) begin err++; $display("FAIL b2b_grant cyc%0d: got req=%b owner=%b want 1 %b", c, mem_req, owner, o); end
        vec++; if (mem_addr !== (o ? 32'h80 : 32'h40)) begin err++; $display("FAIL b2b_addr cyc%0d: got %h", c, mem_addr); end
        vec++; if ({c0_done, c1_done, c0_stall, c1_stall} !== 4'b0011) begin err++; $display("FAIL b2b_ctl cyc%0d: got %b want 0011", c, {c0_done, c1_done, c0_stall, c1_stall}); end
      end else begin
        o = ((c - 2) / 2) % 2 == 1;
        exp = 32'hA000 + c - 1;
        vec++; if ({c0_done, c1_done} !== (o ? 2'b01 : 2'b10)) begin err++; $display("FAIL b2b_done cyc%0d: got %b for core %b", c, {c0_done, c1_done}, o); end
        vec++; if ((o ? c1_rdata : c0_rdata) !== exp) begin err++; $display("FAIL b2b_rdata cyc%0d: got %h want %h", c, o ? c1_rdata : c0_rdata, exp); end
        vec++; if (mem_req !== 1'b0) begin err++; $display("FAIL b2b_gap cyc%0d: got %b want 0", c, mem_req); end
      end
    end
    c0_req = 0; c1_req = 0; mem_ready = 0;
    @(negedge clk); #1;
    vec++; if (busy !== 1'b0) begin err++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
  endtask

  task automatic test_wait_store();
    // cycle 0
    @(negedge clk);
    c1_req = 1; c1_we = 1; c1_addr = 32'h20; c1_wdata = 32'h55; mem_ready = 0; mem_rdata = 32'h77;
    #1;
    vec++; if (c1_stall !== 1'b1 || mem_req !== 1'b0) begin err++; $display("FAIL st_c0: got stall=%b req=%b want 1 0", c1_stall, mem_req); end
    // cycles 1..4: access held stable
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 2) begin c0_req = 1; c0_we = 0; c0_addr = 32'h30; end
      if (c == 4) mem_ready = 1;
      #1;
      vec++; if ({mem_req, mem_we, owner} !== 3'b111) begin err++; $display("FAIL st_ctl cyc%0d: got %b want 111", c, {mem_req, mem_we, owner}); end
      vec++; if (mem_addr !== 32'h20 || mem_wdata !== 32'h55) begin err++; $display("FAIL st_bus cyc%0d: got %h %h want 20 55", c, mem_addr, mem_wdata); end
      vec++; if (c1_done !== 1'b0 || c1_stall !== 1'b1) begin err++; $display("FAIL st_c1 cyc%0d: got done=%b stall=%b", c, c1_done, c1_stall); end
      if (c >= 2) begin
        vec++; if (c0_stall !== 1'b1) begin err++; $display("FAIL st_c0_stall cyc%0d: got %b want 1", c, c0_stall); end
      end
    end
    // cycle 5
    @(negedge clk);
    mem_ready = 0; c1_req = 0; c1_we = 0;
    #1;
    vec++; if (c1_done !== 1'b1 || c1_rdata !== 32'h77) begin err++; $display("FAIL st_done: got %b %h want 1 77", c1_done, c1_rdata); end
    vec++; if (mem_req !== 1'b0 || c0_done !== 1'b0 || c0_stall !== 1'b1) begin err++; $display("FAIL st_c5: got req=%b done0=%b stall0=%b", mem_req, c0_done, c0_stall); end
    // cycle 6: the waiting core 0 request is granted only now
    @(negedge clk);
    mem_ready = 1; mem_rdata = 32'h3333;
    #1;
    vec++; if (mem_req !== 1'b1 || owner !== 1'b0 || mem_we !== 1'b0) begin err++; $display("FAIL st_c0_grant: got req=%b owner=%b we=%b", mem_req, owner, mem_we); end
    vec++; if (mem_addr !== 32'h30) begin err++; $display("FAIL st_c0_addr: got %h want 30", mem_addr); end
    // cycle 7
    @(negedge clk);
    mem_ready = 0; c0_req = 0;
    #1;
    vec++; if (c0_done !== 1'b1 || c0_rdata !== 32'h3333 || c1_done !== 1'b0) begin err++; $display("FAIL st_c0_done: got %b %h %b", c0_done, c0_rdata, c1_done); end
  endtask

  task automatic test_reset_mid_access();
    // cycle 0
    @(negedge clk);
    c0_req = 1; c0_addr = 32'h44; mem_ready = 0;
    // cycle 1
    @(negedge clk);
    rst = 1;
    #1;
    vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin err++; $display("FAIL rma_busy: got %b %h want 1 44", mem_req, mem_addr); end
    // cycle 2
    @(negedge clk);
    rst = 0; c0_req = 0; mem_ready = 1; mem_rdata = 32'h9999;
    #1;
    vec++; if (mem_req !== 1'b0 || busy !== 1'b0) begin err++; $display("FAIL rma_drop: got req=%b busy=%b want 0 0", mem_req, busy); end
    vec++; if (c0_done !== 1'b0 || mem_addr !== 32'h0 || c0_rdata !== 32'h0) begin err++; $display("FAIL rma_regs: got %b %h %h", c0_done, mem_addr, c0_rdata); end
    // cycle 3
    @(negedge clk);
    c1_req = 1; c1_we = 0; c1_addr = 32'h88; mem_rdata = 32'h5A5A;
    #1;
    vec++; if ({c0_done, c1_done, mem_req} !== 3'b000) begin err++; $display("FAIL rma_nodone: got %b want 000", {c0_done, c1_done, mem_req}); end
    // cycle 4
    @(negedge clk); #1;
    vec++; if (mem_req !== 1'b1 || owner !== 1'b1 || mem_addr !== 32'h88) begin err++; $display("FAIL rma_regrant: got %b %b %h", mem_req, owner, mem_addr); end
    // cycle 5
    @(negedge clk);
    c1_req = 0; mem_ready = 0;
    #1;
    vec++; if (c1_done !== 1'b1 || c1_rdata !== 32'h5A5A) begin err++; $display("FAIL rma_c1_done: got %b %h want 1 5a5a", c1_done, c1_rdata); end
  endtask

`ifdef DMEM_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    // cycle 0: locked load from core 0, core 1 competing
    @(negedge clk);
    c0_req = 1; c0_lock = 1; c0_we = 0; c0_addr = 32'h100;
    c1_req = 1; c1_addr = 32'h200; mem_ready = 1; mem_rdata = 32'hAA;
    // cycle 1
    @(negedge clk); #1;
    vec++; if (mem_req !== 1'b1 || owner !== 1'b0) begin err++; $display("FAIL lk_load: got %b %b want 1 0", mem_req, owner); end
    // cycle 2: core 0 turns the request into the store half
    @(negedge clk);
    c0_we = 1; c0_wdata = 32'hBB;
    #1;
    vec++; if (c0_done !== 1'b1 || c0_rdata !== 32'hAA) begin err++; $display("FAIL lk_load_done: got %b %h", c0_done, c0_rdata); end
    vec++; if (busy !== 1'b1 || mem_req !== 1'b0 || c1_stall !== 1'b1) begin err++; $display("FAIL lk_hold_c2: got busy=%b req=%b stall1=%b", busy, mem_req, c1_stall); end
    // cycle 3
    @(negedge clk); #1;
    vec++; if (mem_req !== 1'b0 || owner !== 1'b0 || c1_stall !== 1'b1) begin err++; $display("FAIL lk_hold_c3: got req=%b owner=%b", mem_req, owner); end
    // cycle 4
    @(negedge clk); #1;
    vec++; if ({mem_req, mem_we, owner} !== 3'b110 || mem_wdata !== 32'hBB) begin err++; $display("FAIL lk_store: got %b %h", {mem_req, mem_we, owner}, mem_wdata); end
    // cycle 5: store done, core 0 releases the lock
    @(negedge clk);
    c0_req = 0; c0_lock = 0; c0_we = 0;
    #1;
    vec++; if (c0_done !== 1'b1 || c1_stall !== 1'b1 || busy !== 1'b1) begin err++; $display("FAIL lk_store_done: got %b %b %b", c0_done, c1_stall, busy); end
    // cycle 6
    @(negedge clk); #1;
    vec++; if (busy !== 1'b0 || mem_req !== 1'b0) begin err++; $display("FAIL lk_release: got busy=%b req=%b", busy, mem_req); end
    // cycle 7
    @(negedge clk); #1;
    vec++; if (mem_req !== 1'b1 || owner !== 1'b1 || mem_addr !== 32'h200) begin err++; $display("FAIL lk_c1_grant: got %b %b %h", mem_req, owner, mem_addr); end
    // cycle 8
    @(negedge clk);
    c1_req = 0; mem_ready = 0;
    #1;
    vec++; if (c1_done !== 1'b1) begin err++; $display("FAIL lk_c1_done: got %b want 1", c1_done); end
  endtask
`endif

  initial begin
    vec = 0;
    err = 0;
    rst = 1;
    clear_inputs();
    test_reset();
    test_single_load();
    test_both_request();
    test_back_to_back();
    test_wait_store();
    test_reset_mid_access();
`ifdef DMEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
